aclk_counter_gen: RTL
=====================

Name: aclk_counter_gen

Overview:
- Parametrised successor to the alarm-clock time counter.
- BCD hours:minutes counter with a configurable tick prescaler, selectable 12/24-hour mode, load validation with error pulse, and a day-rollover pulse.
- Sits between the tick generator and the display/alarm-compare logic of the alarm clock.

Parameters:
- TICKS_PER_UNIT, 1: number of tick pulses per count advance. Legal range 1..65535.
- HOUR_12, 0: 0 selects 24-hour mode (00..23); 1 selects 12-hour mode (01..12) with a PM flag.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- tick  input  1  one-cycle advance strobe (one_minute class). Each high cycle counts as one pulse.
- load_new_c  input  1  load request; sampled on the rising edge.
- new_current_time_ms_hr  input  4  BCD hours, tens digit.
- new_current_time_ls_hr  input  4  BCD hours, units digit.
- new_current_time_ms_min  input  4  BCD minutes, tens digit.
- new_current_time_ls_min  input  4  BCD minutes, units digit.
- new_pm  input  1  PM flag to load. Ignored when HOUR_12=0.
- current_ms_hr, current_ls_hr, current_ms_min, current_ls_min  output  4 each  registered BCD time.
- current_pm  output  1  registered PM flag. Constant 0 when HOUR_12=0.
- load_err  output  1  one-cycle pulse: the load was rejected.
- rollover  output  1  one-cycle pulse: the day wrapped.

Behaviour:
- Reset (reset=0 at a clk edge) has priority over everything else.
  - Time goes to 00:00 (24h) or 12:00 AM, current_pm=0 (12h).
  - Prescaler is cleared; load_err=0; rollover=0.
- Priority order: reset, then load_new_c, then tick. A tick in the same cycle as a load is dropped.
- Load validation: every digit must be 0..9. Hours must be 00..23 (24h) or 01..12 (12h); minutes 00..59.
  - Valid load: all digits and current_pm update at the next edge. Prescaler clears to 0. load_err=0.
  - Invalid load: time, pm and prescaler are unchanged. load_err=1 for exactly one cycle.
- Prescaler: a counter of width clog2(TICKS_PER_UNIT), absent when TICKS_PER_UNIT=1.
  - On tick with prescaler < TICKS_PER_UNIT-1: prescaler increments.
  - On tick with prescaler = TICKS_PER_UNIT-1: prescaler goes to 0 and time advances at the same edge.
  - Net latency is 1 cycle from the qualifying tick to the updated outputs.
- Advance, minutes: ls_min 9->0 carries into ms_min; ms_min 5->0 carries into hours.
- Advance, hours, 24h mode: units wrap 9->0 with tens increment (09->10, 19->20).
  - 23:59 -> 00:00 and rollover=1 for one cycle.
- Advance, hours, 12h mode: 09->10; 11:59 -> 12:00 toggles current_pm; 12:59 -> 01:00.
  - 11:59 PM -> 12:00 AM asserts rollover.
- Tick held high for consecutive cycles counts one pulse per cycle.
- Outputs only ever hold legal values. No state is reachable that shows an illegal BCD digit.

Optional Feature:
- Macro: ACLK_SECONDS_EN.
- Defined:
  - Adds outputs current_ms_sec and current_ls_sec (4 bits each, BCD), reset to 00.
  - The prescaled tick advances seconds; minutes advance on the seconds 59->00 carry.
  - A valid load forces seconds to 00; an invalid load leaves seconds unchanged.
  - rollover fires on 23:59:59 -> 00:00:00 (24h), or 11:59:59 PM -> 12:00:00 AM (12h).
- Not defined: no seconds ports; the prescaled tick advances minutes directly.

Test Plan:
- Reset and load, 24h, TICKS_PER_UNIT=1:
  - Assert reset low for one edge -> 00:00, load_err=0, rollover=0.
  - Load 12:59, then one tick -> 13:00. Second tick -> 13:01.
- Hour-digit wrap and day wrap, 24h:
  - Load 09:59, tick -> 10:00.
  - Load 23:59, tick -> 00:00 with rollover=1 for exactly one cycle.
- Invalid loads:
  - Load 24:00 -> time unchanged, load_err pulses once.
  - Load 12:6A -> same result.
  - Load 00:59 -> accepted, load_err=0.
- 12h mode, HOUR_12=1:
  - After reset -> 12:00, pm=0.
  - Load 11:59 AM, tick -> 12:00 PM. Load 12:59 PM, tick -> 01:00 PM.
  - Load 11:59 PM, tick -> 12:00 AM with rollover.
  - Load 00:30 -> load_err.
- Prescaler, TICKS_PER_UNIT=3:
  - Load 00:00, 2 ticks -> still 00:00. 3rd tick -> 00:01.
  - Load mid-count clears the prescaler: a further 3 ticks are needed for the next advance.
- Simultaneous events:
  - load_new_c and tick in the same cycle -> only the load applies.
  - reset low together with load_new_c -> 00:00.
  - With ACLK_SECONDS_EN and TICKS_PER_UNIT=1: load 23:59, then 60 ticks -> 00:00:00 with rollover.

Source files
------------

// File: rtl/aclk_counter_gen_if.sv
// Bus bundle between the tick/load source and the BCD time counter.
// The counter drives the time, PM flag and the one-cycle status pulses.
// Seconds outputs exist only when ACLK_SECONDS_EN is defined.
interface aclk_counter_gen_if;
  logic       tick;
  logic       load_new_c;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic       new_pm;
  logic [3:0] current_ms_hr;
  logic [3:0] current_ls_hr;
  logic [3:0] current_ms_min;
  logic [3:0] current_ls_min;
  logic       current_pm;
  logic       load_err;
  logic       rollover;
`ifdef ACLK_SECONDS_EN
  logic [3:0] current_ms_sec;
  logic [3:0] current_ls_sec;
`endif

  modport master (
`ifdef ACLK_SECONDS_EN
    input  current_ms_sec, current_ls_sec,
`endif
    output tick, load_new_c, new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, new_pm,
    input  current_ms_hr, current_ls_hr, current_ms_min, current_ls_min,
           current_pm, load_err, rollover
  );

  modport slave (
`ifdef ACLK_SECONDS_EN
    output current_ms_sec, current_ls_sec,
`endif
    input  tick, load_new_c, new_current_time_ms_hr, new_current_time_ls_hr,
           new_current_time_ms_min, new_current_time_ls_min, new_pm,
    output current_ms_hr, current_ls_hr, current_ms_min, current_ls_min,
           current_pm, load_err, rollover
  );
endinterface

// File: rtl/aclk_counter_gen.sv
// BCD hh:mm(:ss with ACLK_SECONDS_EN) counter, prescaled tick, 12/24h, load check.
// Latency: 1 cycle from qualifying tick or load to registered outputs.
// No backpressure: every tick/load is consumed; priority reset > load > tick.
module aclk_counter_gen #(
  parameter int TICKS_PER_UNIT = 1,
  parameter int HOUR_12        = 0
) (
  input logic              clk,
  input logic              reset,
  aclk_counter_gen_if.slave bus
);

  logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
  logic       pm_q, pm_d;
  logic       load_err_q, load_err_d;
  logic       roll_q, roll_d;
  logic       load_ok;
  logic       adv;
  logic       min_adv;
  logic       digits_ok, hr_ok;
`ifdef ACLK_SECONDS_EN
  logic [3:0] ms_sec_q, ls_sec_q, ms_sec_d, ls_sec_d;
`endif

  // Validate the requested time; only legal BCD times may ever be loaded.
  always_comb begin
    digits_ok = (bus.new_current_time_ms_hr  <= 4'd9) &&
                (bus.new_current_time_ls_hr  <= 4'd9) &&
                (bus.new_current_time_ms_min <= 4'd5) &&
                (bus.new_current_time_ls_min <= 4'd9);
    if (HOUR_12 != 0)
      hr_ok = ((bus.new_current_time_ms_hr == 4'd0) && (bus.new_current_time_ls_hr != 4'd0)) ||
              ((bus.new_current_time_ms_hr == 4'd1) && (bus.new_current_time_ls_hr <= 4'd2));
    else
      hr_ok = (bus.new_current_time_ms_hr <= 4'd1) ||
              ((bus.new_current_time_ms_hr == 4'd2) && (bus.new_current_time_ls_hr <= 4'd3));
    load_ok = digits_ok && hr_ok;
  end

  generate
    if (TICKS_PER_UNIT > 1) begin : g_presc
      localparam int PW = $clog2(TICKS_PER_UNIT);
      localparam logic [PW-1:0] TOP = PW'(TICKS_PER_UNIT - 1);
      logic [PW-1:0] presc_q, presc_d;

      // Prescaler: clears on an accepted load, wraps on the advancing tick.
      always_comb begin
        presc_d = presc_q;
        if (bus.load_new_c) begin
          if (load_ok) presc_d = '0;
        end else if (bus.tick) begin
          presc_d = (presc_q == TOP) ? '0 : presc_q + 1'b1;
        end
      end

      assign adv = bus.tick && !bus.load_new_c && (presc_q == TOP);

      // Prescaler register.
      always_ff @(posedge clk) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
      end
    end else begin : g_nopresc
      assign adv = bus.tick && !bus.load_new_c;
    end
  endgenerate

  // Next-state: load takes precedence; otherwise ripple the BCD carry chain.
  always_comb begin
    ms_hr_d    = ms_hr_q;
    ls_hr_d    = ls_hr_q;
    ms_min_d   = ms_min_q;
    ls_min_d   = ls_min_q;
    pm_d       = pm_q;
    load_err_d = 1'b0;
    roll_d     = 1'b0;
    min_adv    = 1'b0;
`ifdef ACLK_SECONDS_EN
    ms_sec_d   = ms_sec_q;
    ls_sec_d   = ls_sec_q;
`endif
    if (bus.load_new_c) begin
      if (load_ok) begin
        ms_hr_d  = bus.new_current_time_ms_hr;
        ls_hr_d  = bus.new_current_time_ls_hr;
        ms_min_d = bus.new_current_time_ms_min;
        ls_min_d = bus.new_current_time_ls_min;
        pm_d     = (HOUR_12 != 0) ? bus.new_pm : 1'b0;
`ifdef ACLK_SECONDS_EN
        ms_sec_d = 4'd0;
        ls_sec_d = 4'd0;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adv) begin
`ifdef ACLK_SECONDS_EN
      if (ls_sec_q == 4'd9) begin
        ls_sec_d = 4'd0;
        if (ms_sec_q == 4'd5) begin
          ms_sec_d = 4'd0;
          min_adv  = 1'b1;
        end else begin
          ms_sec_d = ms_sec_q + 4'd1;
        end
      end else begin
        ls_sec_d = ls_sec_q + 4'd1;
      end
`else
      min_adv = 1'b1;
`endif
    end

    if (min_adv) begin
      if (ls_min_q != 4'd9) begin
        ls_min_d = ls_min_q + 4'd1;
      end else begin
        ls_min_d = 4'd0;
        if (ms_min_q != 4'd5) begin
          ms_min_d = ms_min_q + 4'd1;
        end else begin
          ms_min_d = 4'd0;
          if (HOUR_12 != 0) begin
            if (ms_hr_q == 4'd1 && ls_hr_q == 4'd1) begin
              // 11 -> 12 flips AM/PM; leaving PM means the day wrapped.
              ls_hr_d = 4'd2;
              pm_d    = ~pm_q;
              roll_d  = pm_q;
            end else if (ms_hr_q == 4'd1 && ls_hr_q == 4'd2) begin
              ms_hr_d = 4'd0;
              ls_hr_d = 4'd1;
            end else if (ls_hr_q == 4'd9) begin
              ms_hr_d = ms_hr_q + 4'd1;
              ls_hr_d = 4'd0;
            end else begin
              ls_hr_d = ls_hr_q + 4'd1;
            end
          end else begin
            if (ms_hr_q == 4'd2 && ls_hr_q == 4'd3) begin
              ms_hr_d = 4'd0;
              ls_hr_d = 4'd0;
              roll_d  = 1'b1;
            end else if (ls_hr_q == 4'd9) begin
              ms_hr_d = ms_hr_q + 4'd1;
              ls_hr_d = 4'd0;
            end else begin
              ls_hr_d = ls_hr_q + 4'd1;
            end
          end
        end
      end
    end
  end

  // Time/status registers; reset shows midnight in either hour mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_hr_q    <= (HOUR_12 != 0) ? 4'd1 : 4'd0;
      ls_hr_q    <= (HOUR_12 != 0) ? 4'd2 : 4'd0;
      ms_min_q   <= 4'd0;
      ls_min_q   <= 4'd0;
      pm_q       <= 1'b0;
      load_err_q <= 1'b0;
      roll_q     <= 1'b0;
`ifdef ACLK_SECONDS_EN
      ms_sec_q   <= 4'd0;
      ls_sec_q   <= 4'd0;
`endif
    end else begin
      ms_hr_q    <= ms_hr_d;
      ls_hr_q    <= ls_hr_d;
      ms_min_q   <= ms_min_d;
      ls_min_q   <= ls_min_d;
      pm_q       <= pm_d;
      load_err_q <= load_err_d;
      roll_q     <= roll_d;
`ifdef ACLK_SECONDS_EN
      ms_sec_q   <= ms_sec_d;
      ls_sec_q   <= ls_sec_d;
`endif
    end
  end

  assign bus.current_ms_hr  = ms_hr_q;
  assign bus.current_ls_hr  = ls_hr_q;
  assign bus.current_ms_min = ms_min_q;
  assign bus.current_ls_min = ls_min_q;
  assign bus.current_pm     = pm_q;
  assign bus.load_err       = load_err_q;
  assign bus.rollover       = roll_q;
`ifdef ACLK_SECONDS_EN
  assign bus.current_ms_sec = ms_sec_q;
  assign bus.current_ls_sec = ls_sec_q;
`endif

endmodule
